// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS fetch stage (fetch PC, imem req/ack, prefetch FIFO, redirect); ports clk, rst_n (sync, active-low), redirect_valid/redirect_pc, imem_req/imem_addr/imem_ack/imem_rdata, if_valid/if_ready/if_instr/if_pc/if_pc_plus4, plus perf_fetch_cnt/perf_flush_cnt when IFU_PERF_CNT_EN is defined
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [31:0] if_pc_plus4
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q [FIFO_DEPTH];
  logic [31:0] instr_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  logic unused_ok;
  assign unused_ok = ^redirect_pc[1:0];
  always_comb begin
    push = state_q == REQ && imem_ack && !redirect_valid;
    pop = if_valid && if_ready;
    wr_d = redirect_valid ? '0 : wr_q + AW'(push);
    rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
    cnt_d = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    // an unacked request (REQ or DROP) must have its ack swallowed before refetching
    state_d = redirect_valid ? ((state_q != IDLE && !imem_ack) ? DROP : REQ)
            : state_q == IDLE ? (cnt_q < FULL ? REQ : IDLE)
            : state_q == REQ ? ((!imem_ack || cnt_d < FULL) ? REQ : IDLE)
            : (imem_ack ? REQ : DROP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i] <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      if (push) begin
        pc_q[wr_q] <= fetch_pc_q;
        instr_q[wr_q] <= imem_rdata;
      end
    end
  end
  assign imem_req = state_q == REQ;
  assign imem_addr = fetch_pc_q;
  assign if_valid = cnt_q != '0;
  assign if_instr = instr_q[rd_q];
  assign if_pc = pc_q[rd_q];
  assign if_pc_plus4 = if_pc + 32'd4;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d, perf_flush_cnt_q, perf_flush_cnt_d;
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + 32'(pop);
    perf_flush_cnt_d = perf_flush_cnt_q + 32'(redirect_valid);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end
  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;
  localparam logic [31:0] K = 32'h5A5A_0000;
  logic clk = 0, rst_n = 0, redirect_valid = 0, if_ready = 0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_ack = 0, if_valid;
  logic [31:0] imem_addr, imem_rdata = '0, if_instr, if_pc, if_pc_plus4;
  logic w_req, w_ack = 0, w_valid;
  logic [31:0] w_addr, w_rdata = '0, w_instr, w_pc, w_p4;
  logic w_ready = 1, w_redirect = 0;
  logic [31:0] w_redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_f, perf_r, w_pf, w_pr;
`endif
  int checks = 0, fails = 0, lat = 1, cnt = 0, xfers = 0;
  bit busy = 0;
  logic [31:0] maddr = '0, ack_addr = '0;
  logic [31:0] req_log[$], got_pc[$], got_instr[$], got_p4[$], w_pc_q[$], w_p4_q[$], w_instr_q[$];
  always #5 clk = ~clk;
  mips_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(perf_f), .perf_flush_cnt(perf_r),
`endif
    .if_pc_plus4(if_pc_plus4)
  );
  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_ready(w_ready), .if_instr(w_instr), .if_pc(w_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(w_pf), .perf_flush_cnt(w_pr),
`endif
    .if_pc_plus4(w_p4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // memory model, transfer monitor, and a 1-cycle memory for the wrap instance
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
      imem_ack = 0;
    end else begin
      imem_ack = 0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_ack = 1;
          imem_rdata = maddr ^ K;
          ack_addr = maddr;
          busy = 0;
        end
      end else if (imem_req) begin
        busy = 1;
        cnt = lat;
        maddr = imem_addr;
        req_log.push_back(imem_addr);
      end
      if (if_valid && if_ready) begin
        got_pc.push_back(if_pc);
        got_instr.push_back(if_instr);
        got_p4.push_back(if_pc_plus4);
        xfers++;
      end
      if (w_valid && w_pc_q.size() < 3) begin
        w_pc_q.push_back(w_pc);
        w_p4_q.push_back(w_p4);
        w_instr_q.push_back(w_instr);
      end
    end
    w_ack = rst_n && w_req && !w_ack;
    w_rdata = w_addr ^ K;
  end
  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_instr.delete();
    got_p4.delete();
    xfers = 0;
  endtask
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 0;
    clear_logs();
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic wait_xfers(input int n);
    for (int i = 0; i < 300 && got_pc.size() < n; i++) @(negedge clk);
    #1 chk("xfer_count_reached", 32'(got_pc.size() >= n), 32'd1);
  endtask
  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect_valid = 0;
    clear_logs();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    // 1: streaming with 1-cycle memory
    lat = 1;
    if_ready = 1;
    do_reset(2);
    @(negedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc4", if_pc_plus4, 4);
    @(negedge clk); #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    wait_xfers(4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", got_pc[i], 32'(4 * i));
      chk("t1_instr", got_instr[i], 32'(4 * i) ^ K);
      chk("t1_pc4", got_p4[i], 32'(4 * i + 4));
      chk("t1_addr", req_log[i], 32'(4 * i));
    end
    // 2: backpressure fills the FIFO, then drains in order
    if_ready = 0;
    do_reset(1);
    repeat (12) @(negedge clk);
    #1;
    chk("t2_reqs", 32'(req_log.size()), 2);
    chk("t2_req_off", imem_req, 0);
    chk("t2_valid", if_valid, 1);
    chk("t2_pc", if_pc, 0);
    chk("t2_instr", if_instr, K);
    repeat (3) @(negedge clk);
    #1 chk("t2_pc_stable", if_pc, 0);
    @(posedge clk); #1;
    if_ready = 1;
    wait_xfers(3);
    chk("t2_drain0", got_pc[0], 32'h0);
    chk("t2_drain1", got_pc[1], 32'h4);
    chk("t2_drain2", got_pc[2], 32'h8);
    chk("t2_resume", req_log[2], 32'h8);
    // 3: redirect while the request to 0x8 is outstanding
    lat = 3;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      found = req_log.size() > 0 && req_log[req_log.size()-1] == 32'h8;
    end
    chk("t3_req8_seen", 32'(found), 1);
    @(posedge clk); #1;
    redirect_to(32'h40);
    @(negedge clk); #1;
    chk("t3_drop_req", imem_req, 0);
    wait_xfers(1);
    chk("t3_pc", got_pc[0], 32'h40);
    chk("t3_instr", got_instr[0], 32'h40 ^ K);
    chk("t3_addr", req_log[0], 32'h40);
    // 4: redirect coinciding with ack
    lat = 1;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      found = imem_ack && ack_addr == 32'h8;
    end
    chk("t4_ack8_seen", 32'(found), 1);
    redirect_to(32'h103);
    wait_xfers(2);
    chk("t4_pc0", got_pc[0], 32'h100);
    chk("t4_instr0", got_instr[0], 32'h100 ^ K);
    chk("t4_pc1", got_pc[1], 32'h104);
    chk("t4_addr", req_log[0], 32'h100);
    // 6: reset mid-stream with a full FIFO
    if_ready = 0;
    do_reset(1);
    repeat (12) @(negedge clk);
    #1 chk("t6_full_valid", if_valid, 1);
    @(posedge clk); #1;
    rst_n = 0;
    clear_logs();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;
    chk("t6_valid", if_valid, 0);
    chk("t6_req", imem_req, 0);
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_f0", perf_f, 0);
    chk("t6_perf_r0", perf_r, 0);
`endif
    @(posedge clk); #1;
    if_ready = 1;
    for (int i = 0; i < 200 && xfers < 3; i++) @(posedge clk) #1;
    if_ready = 0;
    chk("t6_xfers", 32'(xfers), 3);
    redirect_to(32'h200);
    @(negedge clk); #1;
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_f", perf_f, 3);
    chk("t6_perf_r", perf_r, 1);
`endif
    chk("t6_refetch", req_log.size() > 0 ? req_log[0] : 32'hX, 32'h200);
    // 5: wrap instance with RESET_PC = FFFF_FFF8
    chk("t5_pc0", w_pc_q[0], 32'hFFFF_FFF8);
    chk("t5_pc1", w_pc_q[1], 32'hFFFF_FFFC);
    chk("t5_pc2", w_pc_q[2], 32'h0000_0000);
    chk("t5_pc4_wrap", w_p4_q[1], 32'h0000_0000);
    chk("t5_instr2", w_instr_q[2], K);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
